hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 52 +++++
 rtl/hazard_scoreboard.sv | 140 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Pipeline hazard/scoreboard bundle between the pipeline control (master)
// and hazard_scoreboard (slave).
interface hazard_scoreboard_if #(
  parameter int unsigned REG_AW = 5
);
  // decode stage
  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic [REG_AW-1:0] RdD;
  logic              RegWriteD;
  logic              LongOpD;
  // execute stage
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [REG_AW-1:0] RdE;
  logic              RegWriteE;
  logic              LongStartE;
  logic [1:0]        ResultSrcE;
  logic [1:0]        PCSrcE;
  // memory / write-back stages
  logic [REG_AW-1:0] RdM;
  logic [REG_AW-1:0] RdW;
  logic              RegWriteM;
  logic              RegWriteW;
  // control outputs
  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              LongBusy;
  logic              LongWB;
  logic [REG_AW-1:0] LongRd;
  logic [15:0]       StallCnt;

  modport master (
    output Rs1D, Rs2D, RdD, RegWriteD, LongOpD,
    output Rs1E, Rs2E, RdE, RegWriteE, LongStartE, ResultSrcE, PCSrcE,
    output RdM, RdW, RegWriteM, RegWriteW,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
    input  LongBusy, LongWB, LongRd, StallCnt
  );

  modport slave (
    input  Rs1D, Rs2D, RdD, RegWriteD, LongOpD,
    input  Rs1E, Rs2E, RdE, RegWriteE, LongStartE, ResultSrcE, PCSrcE,
    input  RdM, RdW, RegWriteM, RegWriteW,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
    output LongBusy, LongWB, LongRd, StallCnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit with forwarding, load-use detection and a one-entry scoreboard
// for a fixed-latency multicycle unit. Optional stall-cycle counter enabled
// by defining HAZARD_PERF_EN; otherwise StallCnt is tied to zero.
module hazard_scoreboard #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LONG_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave hz
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WB
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] long_rd_q, long_rd_d;

  logic load_use;
  logic sb_raw;
  logic sb_struct;
  logic hazard;
  logic redirect;

  always_comb begin
    hz.ForwardAE = 2'b00;
    if (hz.RegWriteM && (hz.RdM != '0) && (hz.RdM == hz.Rs1E)) begin
      hz.ForwardAE = 2'b10;
    end else if (hz.RegWriteW && (hz.RdW != '0) && (hz.RdW == hz.Rs1E)) begin
      hz.ForwardAE = 2'b01;
    end
  end

  always_comb begin
    hz.ForwardBE = 2'b00;
    if (hz.RegWriteM && (hz.RdM != '0) && (hz.RdM == hz.Rs2E)) begin
      hz.ForwardBE = 2'b10;
    end else if (hz.RegWriteW && (hz.RdW != '0) && (hz.RdW == hz.Rs2E)) begin
      hz.ForwardBE = 2'b01;
    end
  end

  // WB is excluded from RAW/WAW: the regfile is write-first there.
  always_comb begin
    load_use  = (hz.ResultSrcE == 2'b01) && (hz.RdE != '0) &&
                ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    sb_raw    = (state_q == BUSY) && (long_rd_q != '0) &&
                ((long_rd_q == hz.Rs1D) || (long_rd_q == hz.Rs2D) ||
                 (hz.RegWriteD && (long_rd_q == hz.RdD)));
    sb_struct = (state_q != IDLE) && hz.LongOpD;
    hazard    = load_use || sb_raw || sb_struct;
    redirect  = (hz.PCSrcE != 2'b00);
  end

  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    if (redirect) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (hazard) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    long_rd_d = long_rd_q;
    case (state_q)
      IDLE: begin
        if (hz.LongStartE) begin
          state_d   = BUSY;
          cnt_d     = 4'(LONG_LAT - 1);
          long_rd_d = hz.RdE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = WB;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      long_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      long_rd_q <= long_rd_d;
    end
  end

  assign hz.LongBusy = (state_q != IDLE);
  assign hz.LongWB   = (state_q == WB);
  assign hz.LongRd   = long_rd_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hz.StallD && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.StallCnt = stall_cnt_q;
`else
  assign hz.StallCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed literal checks plus
// randomized traffic against a cycle-age model of the multicycle unit.
module tb_hazard_scoreboard;
  localparam int unsigned AW  = 5;
  localparam int unsigned LAT = 4;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(AW)) bus ();
  hazard_scoreboard #(.REG_AW(AW), .LONG_LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .hz (bus)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Model: m_age counts edges since the start edge (0 = no op in flight).
  int          m_age  = 0;
  logic [AW-1:0] m_rd = '0;
  int          m_scnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] e_fwd(input logic [AW-1:0] rs);
    if (bus.RegWriteM && bus.RdM != 0 && bus.RdM == rs) return 2'b10;
    if (bus.RegWriteW && bus.RdW != 0 && bus.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit e_hz();
    bit lu, raw, st, busy, wb;
    busy = (m_age >= 1) && (m_age < LAT);
    wb   = (m_age == LAT);
    lu   = (bus.ResultSrcE == 2'b01) && (bus.RdE != 0) &&
           (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
    raw  = busy && (m_rd != 0) &&
           (m_rd == bus.Rs1D || m_rd == bus.Rs2D || (bus.RegWriteD && m_rd == bus.RdD));
    st   = (busy || wb) && bus.LongOpD;
    return lu || raw || st;
  endfunction

  function automatic bit e_redir();
    return bus.PCSrcE != 2'b00;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_age  = 0;
      m_rd   = '0;
      m_scnt = 0;
    end else begin
      if (PERF && !e_redir() && e_hz() && m_scnt < 65535) m_scnt++;
      if (m_age == 0) begin
        if (bus.LongStartE) begin
          m_age = 1;
          m_rd  = bus.RdE;
        end
      end else if (m_age == LAT) begin
        m_age = 0;
      end else begin
        m_age++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ForwardAE", 32'(bus.ForwardAE), 32'(e_fwd(bus.Rs1E)));
      chk("ForwardBE", 32'(bus.ForwardBE), 32'(e_fwd(bus.Rs2E)));
      chk("StallF",    32'(bus.StallF),    32'(!e_redir() && e_hz()));
      chk("StallD",    32'(bus.StallD),    32'(!e_redir() && e_hz()));
      chk("FlushD",    32'(bus.FlushD),    32'(e_redir()));
      chk("FlushE",    32'(bus.FlushE),    32'(e_redir() || e_hz()));
      chk("LongBusy",  32'(bus.LongBusy),  32'(m_age != 0));
      chk("LongWB",    32'(bus.LongWB),    32'(m_age == LAT));
      chk("LongRd",    32'(bus.LongRd),    32'(m_rd));
      chk("StallCnt",  32'(bus.StallCnt),  32'(m_scnt));
    end
  end

  task automatic clr();
    bus.Rs1D = '0; bus.Rs2D = '0; bus.RdD = '0; bus.RegWriteD = 1'b0; bus.LongOpD = 1'b0;
    bus.Rs1E = '0; bus.Rs2E = '0; bus.RdE = '0; bus.RegWriteE = 1'b0; bus.LongStartE = 1'b0;
    bus.ResultSrcE = 2'b00; bus.PCSrcE = 2'b00;
    bus.RdM = '0; bus.RdW = '0; bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_reg();
    if ($urandom_range(0, 4) == 4) return m_rd;
    return AW'($urandom_range(0, 3));
  endfunction

  initial begin
    clr();
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    // reset state; combinational paths stay live during reset
    bus.RegWriteM = 1'b1; bus.RdM = 5'd3; bus.Rs1E = 5'd3;
    #2;
    chk("rst_LongBusy", 32'(bus.LongBusy), 32'd0);
    chk("rst_LongWB",   32'(bus.LongWB),   32'd0);
    chk("rst_LongRd",   32'(bus.LongRd),   32'd0);
    chk("rst_StallCnt", 32'(bus.StallCnt), 32'd0);
    chk("rst_FwdA",     32'(bus.ForwardAE), 32'd2);
    next_cyc();
    rst = 1'b1;

    // forwarding priority
    clr();
    bus.RegWriteM = 1'b1; bus.RdM = 5'd5; bus.Rs1E = 5'd5;
    bus.RegWriteW = 1'b1; bus.RdW = 5'd6; bus.Rs2E = 5'd6;
    #2;
    chk("fwd_A_M", 32'(bus.ForwardAE), 32'd2);
    chk("fwd_B_W", 32'(bus.ForwardBE), 32'd1);
    next_cyc();
    bus.RdM = 5'd0; bus.RdW = 5'd5;
    #2;
    chk("fwd_A_W", 32'(bus.ForwardAE), 32'd1);

    // load-use, then redirect override
    next_cyc(); clr();
    bus.ResultSrcE = 2'b01; bus.RdE = 5'd7; bus.Rs2D = 5'd7;
    #2;
    chk("lu_StallF", 32'(bus.StallF), 32'd1);
    chk("lu_StallD", 32'(bus.StallD), 32'd1);
    chk("lu_FlushE", 32'(bus.FlushE), 32'd1);
    chk("lu_FlushD", 32'(bus.FlushD), 32'd0);
    next_cyc();
    bus.PCSrcE = 2'b01;
    #2;
    chk("redir_StallF", 32'(bus.StallF), 32'd0);
    chk("redir_StallD", 32'(bus.StallD), 32'd0);
    chk("redir_FlushD", 32'(bus.FlushD), 32'd1);
    chk("redir_FlushE", 32'(bus.FlushE), 32'd1);

    // multicycle op to r9, RAW on Rs1D
    next_cyc(); clr();
    bus.LongStartE = 1'b1; bus.RdE = 5'd9;
    for (int c = 1; c <= 5; c++) begin
      next_cyc(); clr();
      bus.Rs1D = 5'd9;
      #2;
      chk("long_Busy",   32'(bus.LongBusy), 32'(c <= 4));
      chk("long_WB",     32'(bus.LongWB),   32'(c == 4));
      chk("long_RAW",    32'(bus.StallD),   32'(c <= 3));
      if (c == 4) chk("long_Rd", 32'(bus.LongRd), 32'd9);
    end

    // structural hazard through WB
    next_cyc(); clr();
    bus.LongStartE = 1'b1; bus.RdE = 5'd9;
    for (int c = 1; c <= 5; c++) begin
      next_cyc(); clr();
      bus.LongOpD = 1'b1; bus.Rs1D = 5'd3; bus.Rs2D = 5'd4;
      bus.RegWriteD = 1'b1; bus.RdD = 5'd2;
      #2;
      chk("struct_StallD", 32'(bus.StallD), 32'(c <= 4));
    end

    // WAW on r9, and RdD=9 without RegWriteD does not stall
    next_cyc(); clr();
    bus.LongStartE = 1'b1; bus.RdE = 5'd9;
    next_cyc(); clr();
    bus.RegWriteD = 1'b1; bus.RdD = 5'd9;
    #2;
    chk("waw_StallD", 32'(bus.StallD), 32'd1);
    next_cyc(); clr();
    bus.RdD = 5'd9;
    #2;
    chk("nowr_StallD", 32'(bus.StallD), 32'd0);
    repeat (3) begin next_cyc(); clr(); end

    // asynchronous reset in BUSY cycle 2 discards the op
    next_cyc(); clr();
    bus.LongStartE = 1'b1; bus.RdE = 5'd9;
    next_cyc(); clr();
    next_cyc();
    #2 rst = 1'b0;
    #1;
    chk("arst_Busy", 32'(bus.LongBusy), 32'd0);
    chk("arst_Rd",   32'(bus.LongRd),   32'd0);
    next_cyc();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      next_cyc();
      #2;
      chk("arst_noWB", 32'(bus.LongWB), 32'd0);
    end

    // register 0 never stalls
    next_cyc(); clr();
    bus.LongStartE = 1'b1; bus.RdE = 5'd0;
    next_cyc(); clr();
    bus.Rs1D = 5'd0; bus.RegWriteD = 1'b1; bus.RdD = 5'd0;
    #2;
    chk("r0_Busy",   32'(bus.LongBusy), 32'd1);
    chk("r0_StallD", 32'(bus.StallD),   32'd0);
    repeat (4) begin next_cyc(); clr(); end
    bus.ResultSrcE = 2'b01; bus.RdE = 5'd0; bus.Rs1D = 5'd0;
    #2;
    chk("r0_lu_StallD", 32'(bus.StallD), 32'd0);

    // three load-use stalls from reset
    next_cyc();
    #2 rst = 1'b0;
    next_cyc();
    rst = 1'b1; clr();
    #2;
    chk("perf_zero", 32'(bus.StallCnt), 32'd0);
    bus.ResultSrcE = 2'b01; bus.RdE = 5'd7; bus.Rs1D = 5'd7;
    next_cyc();
    next_cyc();
    next_cyc(); clr();
    #2;
    chk("perf_cnt3", 32'(bus.StallCnt), PERF ? 32'd3 : 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      next_cyc();
      if (!rst) rst = 1'b1;
      bus.Rs1D = rnd_reg(); bus.Rs2D = rnd_reg(); bus.RdD = rnd_reg();
      bus.RegWriteD = 1'($urandom_range(0, 1));
      bus.LongOpD   = ($urandom_range(0, 3) == 0);
      bus.Rs1E = rnd_reg(); bus.Rs2E = rnd_reg(); bus.RdE = rnd_reg();
      bus.RegWriteE  = 1'($urandom_range(0, 1));
      bus.LongStartE = ($urandom_range(0, 3) == 0);
      bus.ResultSrcE = 2'($urandom_range(0, 3));
      bus.PCSrcE     = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.RdM = rnd_reg(); bus.RdW = rnd_reg();
      bus.RegWriteM = 1'($urandom_range(0, 1));
      bus.RegWriteW = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b0;
      end
    end

    next_cyc();
    rst = 1'b1;
    clr();
    next_cyc();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
